// File: rtl/tone_sequencer_pkg.sv
// Shared types and default widths for the tone sequencer and its neighbours.
package tone_pkg;

   // Default widths; DIV_W matches the downstream clock divider's div input.
   localparam int TONE_DIV_W = 28;
   localparam int TONE_DUR_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      PLAY,
      GAP
   } tone_state_t;

   // One table step: divider value (0 = rest) and duration in ticks.
   typedef struct packed {
      logic [TONE_DIV_W-1:0] div;
      logic [TONE_DUR_W-1:0] dur;
   } tone_entry_t;

   // A stored duration of 0 still plays for one tick.
   function automatic logic [TONE_DUR_W-1:0] dur_floor(input logic [TONE_DUR_W-1:0] dur);
      return (dur == '0) ? TONE_DUR_W'(1) : dur;
   endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control/status bundle between the UI logic (master) and the tone sequencer (slave).
interface tone_sequencer_if
   import tone_pkg::*;
#(
   parameter int STEPS = 16,
   parameter int DIV_W = TONE_DIV_W,
   parameter int DUR_W = TONE_DUR_W
);
   localparam int ADDR_W = $clog2(STEPS);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DIV_W-1:0]  wr_div;
   logic [DUR_W-1:0]  wr_dur;
   logic              start;
   logic              stop;
   logic              loop_en;
   logic [ADDR_W-1:0] last_step;
   logic [DIV_W-1:0]  div;
   logic              gate;
   logic [ADDR_W-1:0] step;
   logic              busy;
   logic              done;

   modport master (
      output wr_en, wr_addr, wr_div, wr_dur, start, stop, loop_en, last_step,
      input  div, gate, step, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_div, wr_dur, start, stop, loop_en, last_step,
      output div, gate, step, busy, done
   );

endinterface

// File: rtl/tone_sequencer_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter producing a one-cycle tick; clear restarts the period.
module tick_prescaler #(
   parameter int TICK_DIV = 25000
) (
   input  logic clock_in,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);
   localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_count;

   // Count up, wrapping after the last cycle of the period or when cleared.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (clear || (r_count == LAST)) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign tick = (r_count == LAST);

endmodule

// File: rtl/tone_sequencer.sv
// Note sequencer: plays table steps 0..last_step, driving the divider value and its gate.
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int STEPS    = 16,
   parameter int DIV_W    = TONE_DIV_W,
   parameter int DUR_W    = TONE_DUR_W,
   parameter int TICK_DIV = 25000
) (
   input  logic            clock_in,
   input  logic            reset_n,
   tone_sequencer_if.slave bus
);
   localparam int ADDR_W = $clog2(STEPS);

   tone_state_t       r_state,     w_state_next;
   logic [DIV_W-1:0]  r_div,       w_div_next;
   logic              r_gate,      w_gate_next;
   logic [ADDR_W-1:0] r_step,      w_step_next;
   logic [ADDR_W-1:0] r_last_step, w_last_next;
   logic [DUR_W-1:0]  r_dur_cnt,   w_dur_next;
   logic              r_done,      w_done_next;

   tone_entry_t       r_table [STEPS];
   tone_entry_t       r_rd_entry;

   logic              w_tick;
   logic              w_clear;

   // Every state starts with a fresh prescaler period.
   assign w_clear = (w_state_next != r_state);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .clear    (w_clear),
      .tick     (w_tick)
   );

   // Step table: synchronous write; the read follows the step about to be held so
   // the entry is ready by the end of LOAD. A same-edge write returns old data.
   always_ff @(posedge clock_in) begin
      if (bus.wr_en) begin
         r_table[bus.wr_addr] <= '{div: bus.wr_div, dur: bus.wr_dur};
      end
      r_rd_entry <= r_table[w_step_next];
   end

   // State register and registered outputs.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_div       <= '0;
         r_gate      <= 1'b0;
         r_step      <= '0;
         r_last_step <= '0;
         r_dur_cnt   <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_div       <= w_div_next;
         r_gate      <= w_gate_next;
         r_step      <= w_step_next;
         r_last_step <= w_last_next;
         r_dur_cnt   <= w_dur_next;
         r_done      <= w_done_next;
      end
   end

   // Next-state and next-output decisions; stop overrides everything outside IDLE.
   always_comb begin
      w_state_next = r_state;
      w_div_next   = r_div;
      w_gate_next  = r_gate;
      w_step_next  = r_step;
      w_last_next  = r_last_step;
      w_dur_next   = r_dur_cnt;
      w_done_next  = 1'b0;

      if ((r_state != IDLE) && bus.stop) begin
         w_state_next = IDLE;
         w_gate_next  = 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.start && !bus.stop) begin
                  w_state_next = LOAD;
                  w_step_next  = '0;
                  w_last_next  = bus.last_step;
               end
            end
            LOAD: begin
               w_state_next = PLAY;
               w_div_next   = r_rd_entry.div;
               w_gate_next  = (r_rd_entry.div != '0);
               w_dur_next   = dur_floor(r_rd_entry.dur);
            end
            PLAY: begin
               if (w_tick) begin
                  if (r_dur_cnt == DUR_W'(1)) begin
                     w_state_next = GAP;
                     w_gate_next  = 1'b0;
                  end else begin
                     w_dur_next = r_dur_cnt - DUR_W'(1);
                  end
               end
            end
            GAP: begin
               if (w_tick) begin
                  if (r_step != r_last_step) begin
                     w_state_next = LOAD;
                     w_step_next  = r_step + ADDR_W'(1);
                  end else if (bus.loop_en) begin
                     w_state_next = LOAD;
                     w_step_next  = '0;
                  end else begin
                     w_state_next = IDLE;
                     w_done_next  = 1'b1;
                  end
               end
            end
            default: begin
               w_state_next = IDLE;
            end
         endcase
      end
   end

   assign bus.div  = r_div;
   assign bus.gate = r_gate;
   assign bus.step = r_step;
   assign bus.busy = (r_state != IDLE);
   assign bus.done = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer with TICK_DIV=4: a timeline model plus directed checks.
module tb_tone_sequencer;
   localparam int TICK = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   tone_sequencer_if #(.STEPS(16), .DIV_W(28), .DUR_W(16)) bus ();

   tone_sequencer #(
      .STEPS    (16),
      .DIV_W    (28),
      .DUR_W    (16),
      .TICK_DIV (TICK)
   ) dut (
      .clock_in (clk),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: per-cycle expected outputs ----------------
   typedef struct packed {
      logic [27:0] div;
      logic        gate;
      logic [3:0]  step;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t        q[$];
   exp_t        cur = '0;
   logic [27:0] m_div [16];
   logic [15:0] m_dur [16];
   logic [3:0]  m_last = '0;

   // A step is: one load cycle, dur*TICK sounding cycles, TICK silent cycles.
   task automatic push_step(input logic [3:0] s, input logic [27:0] prev_div);
      int   d;
      exp_t e;
      d = (m_dur[s] == 16'd0) ? 1 : int'(m_dur[s]);
      e = '{div: prev_div, gate: 1'b0, step: s, busy: 1'b1, done: 1'b0};
      q.push_back(e);
      e = '{div: m_div[s], gate: (m_div[s] != 28'd0), step: s, busy: 1'b1, done: 1'b0};
      repeat (d * TICK) q.push_back(e);
      e.gate = 1'b0;
      repeat (TICK) q.push_back(e);
   endtask

   always @(posedge clk or negedge reset_n) begin : model
      exp_t nxt;
      if (!reset_n) begin
         q.delete();
         cur <= '0;
      end else begin
         nxt      = cur;
         nxt.done = 1'b0;
         if (cur.busy && bus.stop) begin
            q.delete();
            nxt.gate = 1'b0;
            nxt.busy = 1'b0;
         end else if (!cur.busy) begin
            if (bus.start && !bus.stop) begin
               m_last = bus.last_step;
               push_step(4'd0, cur.div);
               nxt = q.pop_front();
            end
         end else begin
            if (q.size() == 0) begin
               if (cur.step != m_last)  push_step(4'(cur.step + 4'd1), cur.div);
               else if (bus.loop_en)    push_step(4'd0, cur.div);
               else begin
                  nxt.gate = 1'b0;
                  nxt.busy = 1'b0;
                  nxt.done = 1'b1;
               end
            end
            if (q.size() != 0) nxt = q.pop_front();
         end
         if (bus.wr_en) begin
            m_div[bus.wr_addr] = bus.wr_div;
            m_dur[bus.wr_addr] = bus.wr_dur;
         end
         cur <= nxt;
      end
   end

   // Compare DUT outputs with the model on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_div",  64'(bus.div),  64'(cur.div));
         check("cyc_gate", 64'(bus.gate), 64'(cur.gate));
         check("cyc_step", 64'(bus.step), 64'(cur.step));
         check("cyc_busy", 64'(bus.busy), 64'(cur.busy));
         check("cyc_done", 64'(bus.done), 64'(cur.done));
      end
   end

   // ---------------- stimulus helpers (start and end 1 time unit after a rising edge) ----------------
   task automatic tick_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_entry(input logic [3:0] a, input logic [27:0] d, input logic [15:0] t);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_div  = d;
      bus.wr_dur  = t;
      tick_cycles(1);
      bus.wr_en   = 1'b0;
   endtask

   task automatic run_until_done(input int max_cyc, input int start_at,
                                 output int n, output int gate_n, output int done_n,
                                 output logic [27:0] first_div);
      n = 0; gate_n = 0; done_n = 0; first_div = '0;
      bus.start = 1'b1;
      tick_cycles(1);
      bus.start = 1'b0;
      while (n < max_cyc) begin
         tick_cycles(1);
         n++;
         bus.start = (n == start_at);
         if (n == 1) first_div = bus.div;
         if (bus.gate) gate_n++;
         if (bus.done) begin
            done_n++;
            break;
         end
      end
      bus.start = 1'b0;
      if (done_n == 0) check("done_timeout", 64'(0), 64'(1));
   endtask

   int          n, gn, dn;
   logic [27:0] fdiv;
   bit          saw1, back0, saw500;

   initial begin
      bus.wr_en = 0; bus.wr_addr = '0; bus.wr_div = '0; bus.wr_dur = '0;
      bus.start = 0; bus.stop = 0; bus.loop_en = 0; bus.last_step = '0;

      // Reset values.
      #23;
      check("rst_div",  64'(bus.div),  64'(0));
      check("rst_gate", 64'(bus.gate), 64'(0));
      check("rst_step", 64'(bus.step), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      tick_cycles(1);

      // Two-step sequence: a note then a rest, no looping.
      write_entry(4'd0, 28'd1000, 16'd2);
      write_entry(4'd1, 28'd0,    16'd1);
      bus.last_step = 4'd1;
      run_until_done(60, 0, n, gn, dn, fdiv);
      check("s1_start_to_done", 64'(n),    64'(22));
      check("s1_gate_cycles",   64'(gn),   64'(8));
      check("s1_done_pulses",   64'(dn),   64'(1));
      check("s1_first_div",     64'(fdiv), 64'(1000));
      tick_cycles(1);
      check("s1_done_one_cycle", 64'(bus.done), 64'(0));
      check("s1_idle_busy",      64'(bus.busy), 64'(0));

      // Looping: step returns to 0, no done; then stop aborts.
      bus.loop_en = 1'b1;
      bus.start = 1'b1;
      tick_cycles(1);
      bus.start = 1'b0;
      saw1 = 0; back0 = 0; dn = 0;
      for (int c = 0; c < 60 && !back0; c++) begin
         tick_cycles(1);
         if (bus.done) dn++;
         if (bus.step == 4'd1) saw1 = 1;
         else if (saw1 && bus.step == 4'd0) back0 = 1;
      end
      check("loop_back_to_step0", 64'(back0), 64'(1));
      check("loop_no_done",       64'(dn),    64'(0));
      tick_cycles(3);
      check("loop_playing_gate", 64'(bus.gate), 64'(1));
      bus.stop = 1'b1;
      tick_cycles(1);
      bus.stop = 1'b0;
      check("stop_busy", 64'(bus.busy), 64'(0));
      check("stop_gate", 64'(bus.gate), 64'(0));
      for (int c = 0; c < 4; c++) begin
         tick_cycles(1);
         if (bus.done) dn++;
      end
      check("stop_no_done", 64'(dn), 64'(0));
      bus.loop_en = 1'b0;

      // Zero duration plays one tick; a start during PLAY is ignored.
      write_entry(4'd0, 28'd777, 16'd0);
      bus.last_step = 4'd0;
      run_until_done(40, 2, n, gn, dn, fdiv);
      check("dur0_gate_cycles", 64'(gn), 64'(4));
      check("dur0_total",       64'(n),  64'(9));
      tick_cycles(2);
      check("dur0_start_ignored_idle", 64'(bus.busy), 64'(0));

      // Overwrite step 1 while step 0 plays.
      write_entry(4'd0, 28'd1000, 16'd2);
      write_entry(4'd1, 28'd0,    16'd1);
      bus.last_step = 4'd1;
      bus.start = 1'b1;
      tick_cycles(1);
      bus.start = 1'b0;
      tick_cycles(3);
      write_entry(4'd1, 28'd500, 16'd3);
      saw500 = 0; dn = 0;
      for (int c = 0; c < 60 && dn == 0; c++) begin
         tick_cycles(1);
         if (bus.step == 4'd1 && bus.div == 28'd500 && bus.gate) saw500 = 1;
         if (bus.done) dn++;
      end
      check("overwrite_step1_div500", 64'(saw500), 64'(1));
      check("overwrite_done",         64'(dn),     64'(1));

      // Simultaneous start and stop in IDLE.
      tick_cycles(2);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick_cycles(1);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check("start_stop_idle_busy", 64'(bus.busy), 64'(0));
      tick_cycles(2);
      check("start_stop_idle_busy_later", 64'(bus.busy), 64'(0));

      // Asynchronous reset while step 1 (div 500) is sounding.
      bus.start = 1'b1;
      tick_cycles(1);
      bus.start = 1'b0;
      tick_cycles(16);
      check("pre_reset_div", 64'(bus.div), 64'(500));
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("areset_div",  64'(bus.div),  64'(0));
      check("areset_gate", 64'(bus.gate), 64'(0));
      check("areset_busy", 64'(bus.busy), 64'(0));
      check("areset_step", 64'(bus.step), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      tick_cycles(1);
      write_entry(4'd0, 28'd1000, 16'd2);
      write_entry(4'd1, 28'd0,    16'd1);
      run_until_done(60, 0, n, gn, dn, fdiv);
      check("restart_total",     64'(n),    64'(22));
      check("restart_first_div", 64'(fdiv), 64'(1000));
      tick_cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
